// File: rtl/led_blink_ctrl.sv
// Multi-channel LED blinker: shared tick prescaler plus per-channel
// OFF / ON / BLINK / ONESHOT behaviour, loaded through a one-cycle write port.
module led_blink_ctrl #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int TICK_HZ      = 1000,
    parameter int NUM_LEDS     = 2,
    parameter int PERIOD_W     = 16,
    parameter int RESET_MODE   = 2,
    parameter int RESET_PERIOD = 1000,
    localparam int CH_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_wr,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic                tick,
    output logic [NUM_LEDS-1:0] led,
    output logic [NUM_LEDS-1:0] busy
);

    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        M_OFF     = 2'd0,
        M_ON      = 2'd1,
        M_BLINK   = 2'd2,
        M_ONESHOT = 2'd3
    } mode_e;

    localparam mode_e RST_MODE = (RESET_MODE == 1) ? M_ON :
                                 (RESET_MODE == 2) ? M_BLINK : M_OFF;
    localparam logic  RST_LED  = (RESET_MODE == 1);

    logic [PRE_W-1:0]    pre_q, pre_d;
    mode_e               mode_q   [NUM_LEDS];
    mode_e               mode_d   [NUM_LEDS];
    logic [PERIOD_W-1:0] period_q [NUM_LEDS];
    logic [PERIOD_W-1:0] period_d [NUM_LEDS];
    logic [PERIOD_W-1:0] cnt_q    [NUM_LEDS];
    logic [PERIOD_W-1:0] cnt_d    [NUM_LEDS];
    logic [NUM_LEDS-1:0] led_q, led_d;

    // Period 0 behaves as 1; cnt never exceeds P-1 so the increment cannot wrap.
    function automatic logic at_last(input logic [PERIOD_W-1:0] c,
                                     input logic [PERIOD_W-1:0] p);
        return (p == '0) || ((c + PERIOD_W'(1)) == p);
    endfunction

    assign tick = (pre_q == PRE_W'(DIV - 1));
    assign led  = led_q;

    always_comb begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        led_d = led_q;
        busy  = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            mode_d[i]   = mode_q[i];
            period_d[i] = period_q[i];
            cnt_d[i]    = cnt_q[i];
            busy[i]     = (mode_q[i] == M_ONESHOT);
            if (cfg_wr && (cfg_chan == CH_W'(i))) begin
                mode_d[i]   = mode_e'(cfg_mode);
                period_d[i] = cfg_period;
                cnt_d[i]    = '0;
                led_d[i]    = (cfg_mode != 2'd0);
            end else if (tick) begin
                unique case (mode_q[i])
                    M_BLINK: begin
                        if (at_last(cnt_q[i], period_q[i])) begin
                            cnt_d[i] = '0;
                            led_d[i] = ~led_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + PERIOD_W'(1);
                        end
                    end
                    M_ONESHOT: begin
                        if (at_last(cnt_q[i], period_q[i])) begin
                            cnt_d[i]  = '0;
                            led_d[i]  = 1'b0;
                            mode_d[i] = M_OFF;
                        end else begin
                            cnt_d[i] = cnt_q[i] + PERIOD_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
            led_q <= {NUM_LEDS{RST_LED}};
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode_q[i]   <= RST_MODE;
                period_q[i] <= PERIOD_W'(RESET_PERIOD);
                cnt_q[i]    <= '0;
            end
        end else begin
            pre_q <= pre_d;
            led_q <= led_d;
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode_q[i]   <= mode_d[i];
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Bench for led_blink_ctrl: directed scenarios plus random writes, checked
// every cycle against a tick-count reference model.
module tb_led_blink_ctrl;

    localparam int DIV = 10;
    localparam int NL  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_wr = 1'b0;
    logic [1:0] cfg_chan = 2'd0;
    logic [1:0] cfg_mode = 2'd0;
    logic [7:0] cfg_period = 8'd0;
    logic       tick;
    logic [2:0] led;
    logic [2:0] busy;

    always #5 clk = ~clk;

    led_blink_ctrl #(
        .CLK_HZ(10), .TICK_HZ(1), .NUM_LEDS(NL), .PERIOD_W(8),
        .RESET_MODE(2), .RESET_PERIOD(3)
    ) dut (
        .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_chan(cfg_chan),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period),
        .tick(tick), .led(led), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    // Model: cycles since reset release, and per channel the mode, effective
    // period, ticks seen since the last load, and the lit state at load time.
    int cyc_cnt = 0;
    bit mvalid = 1'b0;
    int m_mode [NL];
    int m_p    [NL];
    int m_n    [NL];
    bit m_base [NL];

    function automatic logic [2:0] exp_led();
        logic [2:0] v;
        v = '0;
        for (int c = 0; c < NL; c++) begin
            case (m_mode[c])
                1: v[c] = 1'b1;
                2: v[c] = m_base[c] ^ (((m_n[c] / m_p[c]) % 2) == 1);
                3: v[c] = (m_n[c] < m_p[c]);
                default: v[c] = 1'b0;
            endcase
        end
        return v;
    endfunction

    function automatic logic [2:0] exp_busy();
        logic [2:0] v;
        v = '0;
        for (int c = 0; c < NL; c++)
            v[c] = (m_mode[c] == 3) && (m_n[c] < m_p[c]);
        return v;
    endfunction

    task automatic cyc();
        logic       et;
        logic [2:0] el;
        logic [2:0] eb;
        bit         t;
        if (mvalid) begin
            et = ((cyc_cnt % DIV) == DIV - 1);
            checks++;
            assert (tick === et) else begin
                failures++;
                $error("FAIL tick: got %b exp %b at cyc %0d", tick, et, cyc_cnt);
            end
        end
        @(posedge clk);
        if (reset) begin
            for (int c = 0; c < NL; c++) begin
                m_mode[c] = 2; m_p[c] = 3; m_n[c] = 0; m_base[c] = 1'b0;
            end
            cyc_cnt = 0;
            mvalid  = 1'b1;
        end else if (mvalid) begin
            t = ((cyc_cnt % DIV) == DIV - 1);
            for (int c = 0; c < NL; c++) begin
                if (cfg_wr && (int'(cfg_chan) == c)) begin
                    m_mode[c] = int'(cfg_mode);
                    m_p[c]    = (cfg_period == 0) ? 1 : int'(cfg_period);
                    m_n[c]    = 0;
                    m_base[c] = (cfg_mode != 2'd0);
                end else if (t && (m_mode[c] >= 2)) begin
                    m_n[c]++;
                end
            end
            cyc_cnt++;
        end
        #1;
        if (mvalid) begin
            el = exp_led();
            eb = exp_busy();
            checks++;
            assert (led === el) else begin
                failures++;
                $error("FAIL led: got %b exp %b at cyc %0d", led, el, cyc_cnt);
            end
            checks++;
            assert (busy === eb) else begin
                failures++;
                $error("FAIL busy: got %b exp %b at cyc %0d", busy, eb, cyc_cnt);
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic wr(input int ch, input int md, input int per);
        cfg_wr     = 1'b1;
        cfg_chan   = 2'(ch);
        cfg_mode   = 2'(md);
        cfg_period = 8'(per);
        cyc();
        cfg_wr = 1'b0;
    endtask

    task automatic align(input int ph);
        while ((cyc_cnt % DIV) != ph) cyc();
    endtask

    initial begin
        // Reset release: toggles land after cycles 29 and 59
        run(5);
        reset = 1'b0;
        run(65);

        // ON then OFF on ch1 while ch0/ch2 blink
        wr(1, 1, 7);
        run(200);
        wr(1, 0, 7);
        run(20);

        // ONESHOT from tick-period phase 0, then a rewrite mid-shot
        align(0);
        wr(2, 3, 4);
        run(45);
        wr(2, 3, 4);
        run(20);
        wr(2, 3, 4);
        run(50);

        // Write landing on a tick cycle
        align(DIV - 1);
        wr(0, 2, 2);
        run(50);

        // Period boundaries and an out-of-range channel
        wr(1, 2, 0);
        run(50);
        wr(2, 2, 255);
        run(2 * 2550 + 20);
        wr(3, 1, 5);
        run(30);
        wr(3, 0, 0);
        run(15);

        // Reset during an active ONESHOT and BLINK
        wr(2, 3, 8);
        wr(0, 2, 2);
        run(25);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        run(65);

        // Random writes with occasional resets
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                cyc();
                reset = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6)));
            end else begin
                cyc();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_blink_ctrl.md
# led_blink_ctrl

Multi-channel LED controller replacing the fixed single-rate board blinker. A shared prescaler divides `clk` down to a slow tick. Each of `NUM_LEDS` channels is independently configured through a single-cycle write port as OFF, ON, BLINK (toggle every N ticks) or ONESHOT (on for N ticks, then off). It sits at the top level, driving board LEDs directly from registered outputs.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: `clk` frequency in Hz.
- `TICK_HZ`, 1000: tick rate. `DIV = CLK_HZ/TICK_HZ`, integer, must be at least 2.
- `NUM_LEDS`, 2: channel count, 1 to 16.
- `PERIOD_W`, 16: width of the per-channel period field, in ticks.
- `RESET_MODE`, 2: mode every channel takes at reset. 0=OFF, 1=ON, 2=BLINK. A value of 3 is treated as OFF.
- `RESET_PERIOD`, 1000: period every channel takes at reset. With the defaults this gives a 1 s toggle.

Ports (`CH_W = max(1, clog2(NUM_LEDS))`):
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `cfg_wr`, in, 1: one-cycle write strobe.
- `cfg_chan`, in, CH_W: target channel.
- `cfg_mode`, in, 2: 0=OFF, 1=ON, 2=BLINK, 3=ONESHOT.
- `cfg_period`, in, PERIOD_W: period in ticks.
- `tick`, out, 1: prescaler strobe, high one `clk` per tick period.
- `led`, out, NUM_LEDS: LED drive, registered.
- `busy`, out, NUM_LEDS: channel currently in ONESHOT.

## Operation
Prescaler:
- Counter `pre` counts 0..DIV-1 and wraps; it runs continuously from reset.
- `tick = (pre == DIV-1)`, a combinational decode.

Per-channel state: `mode` (2 bits), `period` (PERIOD_W), `cnt` (PERIOD_W), `led` bit.
- Effective period `P = (period == 0) ? 1 : period`.
- OFF: `led=0`, `cnt` held at 0, ticks ignored.
- ON: `led=1`, `cnt` held at 0, ticks ignored.
- BLINK: on each tick, if `cnt == P-1` then `cnt=0` and `led` toggles; otherwise `cnt` increments.
- ONESHOT: on each tick, if `cnt == P-1` then `led=0`, `cnt=0` and `mode=OFF`; otherwise `cnt` increments.
- `busy[i] = (mode_i == ONESHOT)`, decoded from the register.

Writes (`cfg_wr=1`):
- `cfg_chan < NUM_LEDS`: at the next edge the channel loads `mode=cfg_mode`, `period=cfg_period` and `cnt=0`.
- `led` after a write: 0 for OFF, 1 for ON, BLINK or ONESHOT. BLINK therefore starts lit.
- `cfg_chan >= NUM_LEDS`: the write is ignored with no state change.
- Write and tick in the same cycle on the same channel: the write wins and that tick is discarded for that channel. Other channels still process the tick.
- Rewriting a channel in ONESHOT restarts the shot from `cnt=0`.
- No arithmetic is performed in PERIOD_W beyond the increment, and `cnt` never exceeds P-1.

Reset (synchronous; the priority is reset, then write, then tick):
- Prescaler: `pre=0`.
- Every channel: `mode=RESET_MODE` (3 maps to OFF), `period=RESET_PERIOD`, `cnt=0`.
- `led = (RESET_MODE==1)` for every channel.
- Resulting outputs: `tick=0`, `busy=0`.
- Asserting reset mid-operation, including mid-ONESHOT, yields exactly these values at the next edge.

## Timing
- Cycle 0 is the first cycle with `reset` low, and `pre=0` in that cycle.
- `tick` is high in cycles DIV-1, 2·DIV-1, and so on.
- A write in cycle k is visible on `led`/`busy` in cycle k+1.
- BLINK: after a write or reset, `led` changes at the edge ending the P-th subsequent tick cycle. Thereafter toggles are exactly P·DIV clocks apart.
- ONESHOT: `led` stays high from the write until the edge ending the P-th tick cycle after the write. The on-time is therefore between (P-1)·DIV+1 and P·DIV clocks, depending on write phase relative to `pre`. `busy` falls on the same edge as `led`.
- Channel state responds to `cfg_*` and the tick on the next edge; there are no combinational paths from `cfg_*` to `led` or `busy`.

## Test plan
All scenarios use `CLK_HZ=10`, `TICK_HZ=1` (DIV=10), `NUM_LEDS=3`, `PERIOD_W=8`, `RESET_MODE=2`, `RESET_PERIOD=3`.
- **Reset release:** hold reset 5 cycles, then release → `tick` high at cycles 9, 19, 29…; `led=000` until the edge after cycle 29, then `111`; back to `000` after cycle 59; `busy=000` throughout.
- **ON/OFF:** write ch1 ON (period 7) → `led[1]=1` next cycle and held through 20 ticks; write ch1 OFF → `led[1]=0` next cycle; ch0 and ch2 keep blinking undisturbed.
- **ONESHOT:** write ch2 ONESHOT period 4 at cycle 0 of a tick period → `led[2]`/`busy[2]` high next cycle, both fall at the edge ending the 4th tick (40 clocks later), and the channel stays OFF afterwards. Rewriting during the shot restarts the 4-tick count.
- **Write on a tick cycle:** write ch0 BLINK period 2 in a cycle with `tick=1` → `led[0]=1`, `cnt` restarts, and the toggle occurs after 2 further ticks (20 clocks); ch1 and ch2 advance on that same tick.
- **Boundaries:** BLINK with period 0 → toggles on every tick. BLINK with period 255 → toggles every 2550 clocks with no counter wrap error. Write to `cfg_chan=3` → no output or state change.
- **Reset mid-operation:** during an active ONESHOT on ch2 and BLINK on ch0, assert reset for 1 cycle → next cycle `led=000`, `busy=000`, `pre=0`, and the scenario-1 sequence repeats.
